// File: rtl/bus_master_port_if.sv
// Processor-side handshake of bus_master_port: level request/command in,
// registered read data with a one-cycle ready/error pulse out.
interface bus_master_port_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int WE_W   = 4
) ();
  logic              P_Read;
  logic [WE_W-1:0]   P_Write;
  logic [ADDR_W-1:0] P_Address;
  logic [DATA_W-1:0] P_Out;
  logic [DATA_W-1:0] P_In;
  logic              P_Ready;
  logic              P_Error;

  modport master (
    output P_Read, P_Write, P_Address, P_Out,
    input  P_In, P_Ready, P_Error
  );

  modport slave (
    input  P_Read, P_Write, P_Address, P_Out,
    output P_In, P_Ready, P_Error
  );
endinterface

// File: rtl/bus_master_port.sv
// Registered bus-master port between one core memory interface and a shared tri-state bus.
// Define BUS_MASTER_TIMEOUT_EN to build the watchdog that aborts hung transfers with P_Error.
module bus_master_port #(
  parameter int ADDR_W   = 30,
  parameter int DATA_W   = 32,
  parameter int WE_W     = 4,
  parameter int HOLD_MAX = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic               clock,
  input  logic               reset_n,
  bus_master_port_if.slave   cpu,
  output logic               Bus_RQ,
  input  logic               Bus_GRANT,
  output wire                Bus_Read,
  output wire  [WE_W-1:0]    Bus_Write,
  output wire  [ADDR_W-1:0]  Bus_Address,
  output wire  [DATA_W-1:0]  Bus_Out,
  input  logic [DATA_W-1:0]  Bus_In,
  input  logic               Bus_Ready
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] OWN  = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] HOLD = 3'd4;
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);

  if (HOLD_MAX < 1 || TIMEOUT < 2) begin : gParamCheck
    $error("bus_master_port: HOLD_MAX must be >= 1 and TIMEOUT >= 2");
  end

  logic [2:0]        state;
  logic              cmdRead;
  logic [WE_W-1:0]   cmdWrite;
  logic [ADDR_W-1:0] cmdAddr;
  logic [DATA_W-1:0] cmdData;
  logic [HOLD_W-1:0] holdCnt;
  logic [DATA_W-1:0] pIn;
  logic              pReady;
  logic              req;
  logic              own;
  logic              burst;
  logic              abort;
  logic              latchCmd;

  assign req      = cpu.P_Read | (|cpu.P_Write);
  assign own      = (state == OWN);
  assign latchCmd = ((state == IDLE) && req) || ((state == HOLD) && burst);

  // The bus is driven only from the latched command, and only while we own it.
  assign Bus_RQ      = (state != IDLE);
  assign Bus_Read    = own ? cmdRead  : 1'bz;
  assign Bus_Write   = own ? cmdWrite : {WE_W{1'bz}};
  assign Bus_Address = own ? cmdAddr  : {ADDR_W{1'bz}};
  assign Bus_Out     = own ? cmdData  : {DATA_W{1'bz}};

  assign cpu.P_In    = pIn;
  assign cpu.P_Ready = pReady;

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT);
  logic [TO_W-1:0] toCnt;
  logic            errFlag;
  logic            pError;

  assign abort       = own && Bus_GRANT && !Bus_Ready && (toCnt == TO_W'(TIMEOUT - 1));
  assign burst       = req && Bus_GRANT && (holdCnt < HOLD_W'(HOLD_MAX)) && !errFlag;
  assign cpu.P_Error = pError;

  // Watchdog counts granted OWN cycles without Bus_Ready; errFlag blocks a burst after an abort.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      toCnt   <= '0;
      errFlag <= 1'b0;
      pError  <= 1'b0;
    end else begin
      pError <= abort;
      if (state == IDLE)
        errFlag <= 1'b0;
      else if (abort)
        errFlag <= 1'b1;
      if (((state == REQ) && req && Bus_GRANT) || ((state == HOLD) && burst))
        toCnt <= '0;
      else if (own && Bus_GRANT && !Bus_Ready && !abort)
        toCnt <= toCnt + TO_W'(1);
    end
  end
`else
  assign abort       = 1'b0;
  assign burst       = req && Bus_GRANT && (holdCnt < HOLD_W'(HOLD_MAX));
  assign cpu.P_Error = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cmdRead  <= 1'b0;
      cmdWrite <= '0;
      cmdAddr  <= '0;
      cmdData  <= '0;
    end else if (latchCmd) begin
      cmdRead  <= cpu.P_Read;
      cmdWrite <= cpu.P_Write;
      cmdAddr  <= cpu.P_Address;
      cmdData  <= cpu.P_Out;
    end
  end

  // Revocation in OWN outranks Bus_Ready: the retained command restarts from REQ.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      holdCnt <= '0;
      pIn     <= '0;
      pReady  <= 1'b0;
    end else begin
      pReady <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            holdCnt <= '0;
            state   <= REQ;
          end
        end
        REQ: begin
          if (!req)
            state <= IDLE;
          else if (Bus_GRANT)
            state <= OWN;
        end
        OWN: begin
          if (!Bus_GRANT) begin
            state <= REQ;
          end else if (Bus_Ready) begin
            pIn     <= cmdRead ? Bus_In : '0;
            holdCnt <= holdCnt + HOLD_W'(1);
            pReady  <= 1'b1;
            state   <= DONE;
          end else if (abort) begin
            pIn    <= '0;
            pReady <= 1'b1;
            state  <= DONE;
          end
        end
        DONE:    state <= HOLD;
        HOLD:    state <= burst ? OWN : IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_master_port.sv
// Scoreboard bench for bus_master_port: directed protocol cases plus a randomized
// memory responder, checked against a byte-lane memory model kept in the bench.
module tb_bus_master_port;
  localparam int ADDR_W   = 30;
  localparam int DATA_W   = 32;
  localparam int WE_W     = 4;
  localparam int HOLD_MAX = 2;
  localparam int TIMEOUT  = 8;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } respT;

  typedef struct packed {
    logic        rd;
    logic [3:0]  we;
    logic [29:0] addr;
    logic [31:0] data;
  } busCmdT;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  bus_master_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WE_W(WE_W)) cpu ();

  logic        busRQ;
  logic        busGrant, busReady;
  logic [31:0] busIn;
  tri0         busRead;
  tri0 [3:0]   busWrite;
  tri0 [29:0]  busAddress;
  tri0 [31:0]  busOut;

  logic        autoResp = 1'b0;
  logic        autoGrant, autoReady;
  logic [31:0] autoIn;
  logic        manGrant = 1'b0, manReady = 1'b0;
  logic [31:0] manIn = '0;
  int          grantPct = 100, readyPct = 100, stallCnt = 0;

  assign busGrant = autoResp ? autoGrant : manGrant;
  assign busReady = autoResp ? autoReady : manReady;
  assign busIn    = autoResp ? autoIn    : manIn;

  bus_master_port #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WE_W(WE_W), .HOLD_MAX(HOLD_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .cpu(cpu),
    .Bus_RQ(busRQ), .Bus_GRANT(busGrant),
    .Bus_Read(busRead), .Bus_Write(busWrite), .Bus_Address(busAddress), .Bus_Out(busOut),
    .Bus_In(busIn), .Bus_Ready(busReady)
  );

  int total = 0, bad = 0, rqLowTotal = 0;
  respT   expQ[$];
  busCmdT expBus[$];
  logic [31:0] modelMem [logic [29:0]];
  logic [31:0] respMem  [logic [29:0]];

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] initWord(input logic [29:0] a);
    return {2'b00, a} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] modelRead(input logic [29:0] a);
    return modelMem.exists(a) ? modelMem[a] : initWord(a);
  endfunction

  function automatic void modelWrite(input logic [29:0] a, input logic [3:0] we, input logic [31:0] d);
    logic [31:0] w;
    w = modelRead(a);
    for (int b = 0; b < 4; b++)
      if (we[b]) w[8*b +: 8] = d[8*b +: 8];
    modelMem[a] = w;
  endfunction

  function automatic logic [66:0] busVec();
    return {busRead, busWrite, busAddress, busOut};
  endfunction

  // Scoreboard monitor: every P_Ready pulse consumes exactly one expected response.
  always @(negedge clock) begin
    respT e;
    if (reset_n && cpu.P_Ready) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpectedReady: got P_Ready=1 expected no pending transaction");
      end else begin
        e = expQ.pop_front();
        checkOutput("readData", cpu.P_In, e.data);
        checkOutput("errorFlag", cpu.P_Error, e.err);
      end
    end
  end

  always @(negedge clock)
    if (reset_n && !busRQ) rqLowTotal++;

  // Memory/arbiter responder used in the randomized and burst phases.
  initial begin
    busCmdT e;
    logic [31:0] w;
    autoGrant = 1'b0;
    autoReady = 1'b0;
    autoIn    = '0;
    forever begin
      @(posedge clock);
      #1;
      autoReady = 1'b0;
      autoIn    = $urandom;
      autoGrant = busRQ && ($urandom_range(99) < grantPct);
      if (autoResp && autoGrant && (busRead || busWrite != 4'h0)) begin
        if (stallCnt >= 3 || $urandom_range(99) < readyPct) begin
          autoReady = 1'b1;
          stallCnt  = 0;
          if (expBus.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpectedBusCommand: got addr %0h expected none", busAddress);
          end else begin
            e = expBus.pop_front();
            checkOutput("busCommand", {busRead, busWrite, busAddress, busRead ? 32'h0 : busOut},
                        {e.rd, e.we, e.addr, e.rd ? 32'h0 : e.data});
          end
          w = respMem.exists(busAddress) ? respMem[busAddress] : initWord(busAddress);
          if (busRead) begin
            autoIn = w;
          end else begin
            for (int b = 0; b < 4; b++)
              if (busWrite[b]) w[8*b +: 8] = busOut[8*b +: 8];
            respMem[busAddress] = w;
          end
        end else begin
          stallCnt++;
        end
      end else if (!(busRead || busWrite != 4'h0)) begin
        stallCnt = 0;
      end
    end
  end

  task automatic waitReady(input int limit, output int cycles);
    cycles = 0;
    forever begin
      @(negedge clock);
      cycles++;
      if (cpu.P_Ready) break;
      if (cycles >= limit) begin
        total++;
        bad++;
        $display("[TB] FAIL readyTimeout: got no P_Ready after %0d cycles expected a pulse", cycles);
        break;
      end
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic [3:0] we, input logic [29:0] addr,
                               input logic [31:0] data, input respT exp, output int cycles);
    @(posedge clock);
    #1;
    cpu.P_Read    = rd;
    cpu.P_Write   = we;
    cpu.P_Address = addr;
    cpu.P_Out     = data;
    expQ.push_back(exp);
    if (autoResp) expBus.push_back({rd, we, addr, data});
    waitReady(300, cycles);
  endtask

  task automatic issueRandom(input logic rd, input logic [29:0] addr, input logic [3:0] we, input logic [31:0] data);
    respT exp;
    int n;
    exp.err = 1'b0;
    if (rd) begin
      exp.data = modelRead(addr);
    end else begin
      exp.data = '0;
      modelWrite(addr, we, data);
    end
    applyStimulus(rd, rd ? 4'h0 : we, addr, data, exp, n);
  endtask

  task automatic idleCycles(input int n);
    @(posedge clock);
    #1;
    cpu.P_Read  = 1'b0;
    cpu.P_Write = 4'h0;
    repeat (n) @(posedge clock);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL globalWatchdog: got simulation still running expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, s1, s2, s3;
    logic rd;
    respT e;

    // Reset with random inputs, then release with no request.
    reset_n       = 1'b0;
    cpu.P_Read    = 1'($urandom);
    cpu.P_Write   = 4'($urandom);
    cpu.P_Address = 30'($urandom);
    cpu.P_Out     = $urandom;
    manGrant      = 1'($urandom);
    manReady      = 1'($urandom);
    manIn         = $urandom;
    repeat (3) @(negedge clock);
    checkOutput("resetRQ", busRQ, 1'b0);
    checkOutput("resetReady", cpu.P_Ready, 1'b0);
    checkOutput("resetPIn", cpu.P_In, 32'h0);
    checkOutput("resetError", cpu.P_Error, 1'b0);
    checkOutput("resetBusReleased", busVec(), 67'h0);
    cpu.P_Read  = 1'b0;
    cpu.P_Write = 4'h0;
    manGrant    = 1'b0;
    manReady    = 1'b0;
    manIn       = '0;
    #1 reset_n  = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("idleAfterResetRQ", busRQ, 1'b0);
    checkOutput("idleAfterResetBus", busVec(), 67'h0);
    checkOutput("idleAfterResetReady", cpu.P_Ready, 1'b0);

    // Single read with grant in cycle 3.
    @(posedge clock);
    #1;
    cpu.P_Read    = 1'b1;
    cpu.P_Address = 30'h10;
    cpu.P_Out     = $urandom;
    @(posedge clock);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      checkOutput("rqBeforeGrant", busRQ, 1'b1);
      checkOutput("busReleasedBeforeGrant", busVec(), 67'h0);
      if (c == 3) manGrant = 1'b1;
      @(posedge clock);
    end
    @(negedge clock);
    checkOutput("readDriven", busRead, 1'b1);
    checkOutput("readAddress", busAddress, 30'h10);
    e.data = 32'hDEADBEEF;
    e.err  = 1'b0;
    expQ.push_back(e);
    manReady = 1'b1;
    manIn    = 32'hDEADBEEF;
    @(negedge clock);
    manReady = 1'b0;
    manIn    = '0;
    checkOutput("readyPulseHigh", cpu.P_Ready, 1'b1);
    checkOutput("busReleasedInDone", busVec(), 67'h0);
    cpu.P_Read = 1'b0;
    manGrant   = 1'b0;
    @(negedge clock);
    checkOutput("readyPulseLow", cpu.P_Ready, 1'b0);
    checkOutput("readDataHeld", cpu.P_In, 32'hDEADBEEF);
    repeat (2) @(negedge clock);

    // Write revoked two cycles into OWN, then re-granted.
    cpu.P_Write   = 4'hF;
    cpu.P_Address = 30'h2A;
    cpu.P_Out     = 32'hA5A5A5A5;
    manGrant      = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("writeDriven", {busWrite, busOut}, {4'hF, 32'hA5A5A5A5});
    @(negedge clock);
    manGrant = 1'b0;
    @(negedge clock);
    checkOutput("revokeReleased", busVec(), 67'h0);
    checkOutput("revokeRQ", busRQ, 1'b1);
    checkOutput("revokeNoReady", cpu.P_Ready, 1'b0);
    checkOutput("revokePInHeld", cpu.P_In, 32'hDEADBEEF);
    manGrant = 1'b1;
    @(negedge clock);
    checkOutput("regrantRQ", busRQ, 1'b1);
    @(negedge clock);
    checkOutput("regrantRedrive", busVec(), {1'b0, 4'hF, 30'h2A, 32'hA5A5A5A5});
    e.data = 32'h0;
    e.err  = 1'b0;
    expQ.push_back(e);
    manReady = 1'b1;
    @(negedge clock);
    manReady    = 1'b0;
    manGrant    = 1'b0;
    cpu.P_Write = 4'h0;
    repeat (3) @(negedge clock);
    checkOutput("writeCompletesOnce", cpu.P_Ready, 1'b0);

    // Burst of three reads with the grant held; HOLD_MAX=2 forces one IDLE gap.
    autoResp = 1'b1;
    grantPct = 100;
    readyPct = 100;
    issueRandom(1'b1, 30'h101, 4'h0, $urandom);
    s1 = rqLowTotal;
    issueRandom(1'b1, 30'h102, 4'h0, $urandom);
    s2 = rqLowTotal;
    issueRandom(1'b1, 30'h103, 4'h0, $urandom);
    s3 = rqLowTotal;
    checkOutput("burstKeepsRQ", s2 - s1, 0);
    checkOutput("burstIdleGap", s3 - s2, 1);
    idleCycles(2);

    // Randomized traffic with grant revocations and variable memory latency.
    grantPct = 85;
    readyPct = 50;
    for (int i = 0; i < 60; i++) begin
      rd = 1'($urandom);
      issueRandom(rd, 30'h100 + 30'($urandom_range(7)), 4'($urandom_range(15, 1)), $urandom);
      if ($urandom_range(1) == 1) idleCycles($urandom_range(3));
    end
    issueRandom(1'b1, 30'h100 + 30'($urandom_range(7)), 4'h0, $urandom);
    idleCycles(4);
    autoResp = 1'b0;

`ifdef BUS_MASTER_TIMEOUT_EN
    // Grant held, Bus_Ready never arrives: abort after TIMEOUT OWN cycles.
    manGrant = 1'b1;
    e.data   = 32'h0;
    e.err    = 1'b1;
    applyStimulus(1'b1, 4'h0, 30'h77, $urandom, e, n);
    checkOutput("timeoutLatency", n, 11);
    @(posedge clock);
    #1;
    cpu.P_Read = 1'b0;
    @(negedge clock);
    checkOutput("timeoutHoldRQ", busRQ, 1'b1);
    @(negedge clock);
    checkOutput("timeoutReleaseRQ", busRQ, 1'b0);
    manGrant = 1'b0;
    repeat (2) @(negedge clock);
`endif

    // Asynchronous reset in the middle of an OWN cycle.
    manGrant = 1'b1;
    @(posedge clock);
    #1;
    cpu.P_Read    = 1'b1;
    cpu.P_Address = 30'h33;
    repeat (3) @(negedge clock);
    checkOutput("ownBeforeReset", {busRead, busAddress}, {1'b1, 30'h33});
    #1 reset_n = 1'b0;
    #1;
    checkOutput("asyncResetRQ", busRQ, 1'b0);
    checkOutput("asyncResetBus", busVec(), 67'h0);
    checkOutput("asyncResetReady", cpu.P_Ready, 1'b0);
    cpu.P_Read = 1'b0;
    manGrant   = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("noReadyAfterReset", cpu.P_Ready, 1'b0);

    checkOutput("pendingResponses", expQ.size(), 0);
    checkOutput("pendingBusCommands", expBus.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_master_port.md
# bus_master_port

Registered, parametrised bus-master port between one MIPS32 core memory interface and a shared, tri-stated system bus. It is the next-generation arbitration submodule: one instance per core per bus (data and instruction).
- A small FSM holds the arbiter request until a full transaction completes.
- It latches the command so it stays stable while waiting.
- It captures read data and returns a one-cycle ready pulse.
- It retries when grant is revoked mid-transfer, keeps the grant for a bounded burst of back-to-back accesses, and optionally aborts hung transfers with an error.

## Interface
Parameters:
- ADDR_W, 30, word-address width
- DATA_W, 32, data width
- WE_W, 4, byte-write-enable width (set to 1 and tie P_Write low for the instruction bus)
- HOLD_MAX, 4, maximum transactions per grant (≥1)
- TIMEOUT, 255, cycles in OWN without Bus_Ready before abort (≥2)

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- P_Read  in  1  processor read request, level
- P_Write  in  WE_W  processor byte write enables, level
- P_Address  in  ADDR_W  processor address
- P_Out  in  DATA_W  processor write data
- P_In  out  DATA_W  registered read data to processor
- P_Ready  out  1  one-cycle transaction-complete pulse
- P_Error  out  1  qualifies P_Ready: transfer aborted (timeout)
- Bus_RQ  out  1  request to bus arbiter
- Bus_GRANT  in  1  grant from bus arbiter
- Bus_Read  out  1  tri-state; driven only in OWN
- Bus_Write  out  WE_W  tri-state; driven only in OWN
- Bus_Address  out  ADDR_W  tri-state; driven only in OWN
- Bus_Out  out  DATA_W  tri-state; driven only in OWN
- Bus_In  in  DATA_W  bus read data
- Bus_Ready  in  1  memory completion, sampled only in OWN

## Operation
- Define req = P_Read | (|P_Write).
- State IDLE:
  - Bus_RQ=0, bus outputs Z.
  - If req, latch {P_Read, P_Write, P_Address, P_Out} into the command register, clear hold_cnt, and go to REQ.
- State REQ:
  - Bus_RQ=1.
  - If req=0 (processor withdrew), go to IDLE.
  - Else if Bus_GRANT=1, go to OWN and clear to_cnt.
- State OWN:
  - Bus_RQ=1 and bus outputs driven from the command register, never directly from P_*.
  - Bus_GRANT=0 (revocation) has priority over Bus_Ready: tri-state from the next cycle and go to REQ with the command retained, so the transaction restarts.
  - Else if Bus_Ready=1: capture P_In<=Bus_In when the command is a read (P_In<=0 for a write), increment hold_cnt, and go to DONE.
  - Else increment to_cnt; when to_cnt reaches TIMEOUT-1, set P_In<=0 and the error flag, and go to DONE.
- State DONE (one cycle):
  - P_Ready=1; P_Error=1 if aborted; Bus_RQ=1; bus outputs Z.
  - Always go to HOLD.
- State HOLD (one cycle):
  - Bus_RQ=1 and bus outputs Z.
  - Burst condition: req, Bus_GRANT, hold_cnt<HOLD_MAX and no error. If it holds, latch the new command and go to OWN.
  - Else go to IDLE (Bus_RQ falls the next cycle); a pending req then re-enters REQ normally.
- Timeout abort always returns to IDLE through DONE/HOLD, releasing the bus.
- P_Ready, P_Error and P_In are registered. P_In holds its value until the next completion.
- Counter widths: hold_cnt is $clog2(HOLD_MAX+1) bits and to_cnt is $clog2(TIMEOUT) bits. Neither wraps: each is reset on entry to its state.

## Timing
- Reset (async, immediate): state=IDLE, Bus_RQ=0, P_Ready=0, P_Error=0, P_In=0, all Bus_* outputs Z, counters and command register 0.
- Reset mid-OWN: bus released (Z) asynchronously, with no P_Ready.
- Minimum latency with immediate grant:
  - req first seen at edge 0.
  - Bus_RQ=1 in cycle 1.
  - Grant sampled at edge 1; bus driven in cycle 2.
  - Bus_Ready sampled at edge k; P_Ready high in cycle k+1.
- Burst: the next transaction's bus drive starts 2 cycles after the previous P_Ready pulse (DONE, then HOLD).
- The processor must hold req and the command stable until P_Ready. Changes while in REQ/OWN are ignored, except withdrawal in REQ.
- The arbiter may deassert Bus_GRANT at any cycle. The port releases within one cycle.

## Configuration
- BUS_MASTER_TIMEOUT_EN defined: the to_cnt watchdog and abort path exist, and P_Error is functional.
- Not defined: no to_cnt. OWN waits indefinitely for Bus_Ready or revocation, P_Error is tied 0, and the TIMEOUT parameter is unused.

## Test plan
- Reset: with reset_n=0 and random inputs, check Bus_RQ=0, P_Ready=0, P_In=0 and all Bus_* at Z. Release reset with req=0 and check the outputs do not change.
- Single read, grant at cycle 3:
  - Stimulus: P_Read=1, P_Address=0x10.
  - Required: Bus_RQ=1 from cycle 1, Bus_Read=1 and Bus_Address=0x10 from cycle 4.
  - Then Bus_Ready with Bus_In=0xDEADBEEF → P_Ready=1 and P_In=0xDEADBEEF for exactly one cycle, with P_Error=0.
- Revocation:
  - Stimulus: write P_Write=4'b1111, P_Out=0xA5A5A5A5; drop grant 2 cycles into OWN.
  - Required: Bus_* at Z next cycle, Bus_RQ stays 1, no P_Ready.
  - On re-grant the same command is redriven and completes once.
- Burst, HOLD_MAX=2: three back-to-back reads, each req asserted right after its P_Ready, grant held high. The first two complete without Bus_RQ falling; Bus_RQ drops for one cycle (IDLE) before the third.
- Timeout (macro defined, TIMEOUT=8): grant given, Bus_Ready never asserted → P_Ready=1 with P_Error=1 and P_In=0 in the cycle after the 8th OWN cycle, then Bus_RQ=0.
- Async reset mid-OWN: assert reset_n=0 in the middle of a clock cycle → Bus_* at Z and Bus_RQ=0 immediately, without waiting for an edge.
